// File: rtl/serial_tx_engine.sv
// serial_tx_engine: TX FIFO plus UART transmit FSM.
//
// A DEPTH-entry FIFO (DATA_W wide) feeds a frame generator that supports
// 5..DATA_W data bits, none/even/odd/mark parity, one or two stop bits and
// break generation. All line changes and state changes occur on baud_tick.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            permits new frames to start
//   baud_tick         one-clock pulse per bit period
//   wr_data, wr_req   FIFO push (dropped while full, sets overflow)
//   clear_overflow    clears the sticky overflow flag (a same-cycle set wins)
//   size              data bits = 5+size, clamped to DATA_W
//   parity            00 none, 01 even, 10 odd, 11 mark
//   stop2             two stop bits when 1
//   brk               break request
//   wm_level          watermark threshold for below_wm
//   tx                serial line, idle high (registered)
//   busy              frame or break in progress
//   empty/full/count  FIFO status
//   overflow          sticky push-while-full flag
//   below_wm          count <= wm_level
//   tx_done           one-clock pulse after each data frame's last stop bit
//
// Optional build macro SERIAL_TX_CTS_EN adds input cts_n (active low,
// already synchronised); data frames start only while cts_n=0.

module serial_tx_engine #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 9,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_req,
  input  logic              clear_overflow,
  input  logic [2:0]        size,
  input  logic [1:0]        parity,
  input  logic              stop2,
  input  logic              brk,
  input  logic [IDX_W:0]    wm_level,
`ifdef SERIAL_TX_CTS_EN
  input  logic              cts_n,
`endif
  output logic              tx,
  output logic              busy,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic [IDX_W:0]    count,
  output logic              below_wm,
  output logic              tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BREAK
  } state_t;

  state_t state, state_next;

  // FIFO storage and status
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [IDX_W:0]    count_q;
  logic              overflow_q;
  logic              push, pop;

  // Frame datapath
  logic [DATA_W-1:0] shift_q;
  logic [3:0]        nbits_q, bit_cnt_q, nbits_cfg;
  logic [1:0]        par_mode_q;
  logic              stop2_q, par_acc_q, brk_mode_q;
  logic              tx_q, tx_next, tx_done_q, par_bit;

  // Launch decision
  logic cts_ok, frame_end, decide, launch_brk, launch_data;

`ifdef SERIAL_TX_CTS_EN
  assign cts_ok = ~cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  assign full     = (count_q == (IDX_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign below_wm = (count_q <= wm_level);
  assign tx       = tx_q;
  assign tx_done  = tx_done_q;

  // full is taken before any same-cycle pop, so a push while full is
  // dropped even when the FSM pops on the same clock.
  assign push = wr_req & ~full;

  // The launch decision applies in IDLE and on the tick that ends the
  // final stop bit, which makes back-to-back frames gapless.
  assign frame_end   = ((state == S_STOP1) && !stop2_q) || (state == S_STOP2);
  assign decide      = (state == S_IDLE) || frame_end;
  assign launch_brk  = brk;
  assign launch_data = ~brk & enable & ~empty & cts_ok;
  assign pop         = baud_tick & decide & launch_data;

  always_comb begin
    if ((size > 3'd4) || (({1'b0, size} + 4'd5) > 4'(DATA_W)))
      nbits_cfg = 4'(DATA_W);
    else
      nbits_cfg = {1'b0, size} + 4'd5;
  end

  // FIFO
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_idx <= wr_idx + 1'b1;
      if (pop)
        rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_req & full)
        overflow_q <= 1'b1;
      else if (clear_overflow)
        overflow_q <= 1'b0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (baud_tick) begin
      case (state)
        S_START:  state_next = S_DATA;
        S_DATA:   if (bit_cnt_q == nbits_q)
                    state_next = (par_mode_q != 2'b00) ? S_PARITY : S_STOP1;
        S_PARITY: state_next = S_STOP1;
        S_STOP1:  if (stop2_q) state_next = S_STOP2;
        S_BREAK:  if (!brk) state_next = S_STOP1;
        default:  state_next = state;
      endcase
      if (decide) begin
        if (launch_brk)
          state_next = S_BREAK;
        else if (launch_data)
          state_next = S_START;
        else
          state_next = S_IDLE;
      end
    end
  end

  // FSM: outputs. The line level for the coming bit period is a function of
  // the state being entered, registered into tx_q on the tick.
  always_comb begin
    busy = (state != S_IDLE);
    case (par_mode_q)
      2'b01:   par_bit = par_acc_q;
      2'b10:   par_bit = ~par_acc_q;
      default: par_bit = 1'b1;
    endcase
    case (state_next)
      S_START, S_BREAK: tx_next = 1'b0;
      S_DATA:           tx_next = shift_q[0];
      S_PARITY:         tx_next = par_bit;
      default:          tx_next = 1'b1;
    endcase
  end

  // Frame datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      shift_q    <= '0;
      nbits_q    <= '0;
      bit_cnt_q  <= '0;
      par_mode_q <= '0;
      stop2_q    <= 1'b0;
      par_acc_q  <= 1'b0;
      brk_mode_q <= 1'b0;
    end else begin
      tx_done_q <= baud_tick & frame_end & ~brk_mode_q;
      if (baud_tick) begin
        tx_q <= tx_next;
        if (pop) begin
          shift_q    <= mem[rd_idx];
          nbits_q    <= nbits_cfg;
          par_mode_q <= parity;
          stop2_q    <= stop2;
          brk_mode_q <= 1'b0;
        end else if (decide && launch_brk) begin
          // Break reuses STOP1 as its single mark bit and never reports done.
          brk_mode_q <= 1'b1;
          stop2_q    <= 1'b0;
        end
        if (state == S_START) begin
          shift_q   <= shift_q >> 1;
          par_acc_q <= shift_q[0];
          bit_cnt_q <= 4'd1;
        end else if ((state == S_DATA) && (state_next == S_DATA)) begin
          shift_q   <= shift_q >> 1;
          par_acc_q <= par_acc_q ^ shift_q[0];
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end
    end
  end

endmodule
